// File: rtl/vp_pkg.sv
// Shared constants, state encoding and lane helper for the shader vector responder.
package vp_pkg;

  localparam int VP_DW = 16;
  localparam int VP_VW = 4;

  localparam logic [3:0] OP_ADD    = 4'd0;
  localparam logic [3:0] OP_SUB    = 4'd1;
  localparam logic [3:0] OP_MUL    = 4'd2;
  localparam logic [3:0] OP_DOT    = 4'd3;
  localparam logic [3:0] OP_SCALE  = 4'd4;
  localparam logic [3:0] OP_LENGTH = 4'd5;

  localparam logic [15:0] FP_ONE    = 16'h0100;
  localparam int          SQRT_ITER = 17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SQRT
  } vp_state_t;

  // Lane 0 is the most-significant slice of the packed vector.
  function automatic logic [VP_DW-1:0] lane_slice(input logic [VP_VW*VP_DW-1:0] vec, input int idx);
    return vec[(VP_VW-idx)*VP_DW-1 -: VP_DW];
  endfunction

endpackage

// File: rtl/vector_processor_if.sv
// Command/result bundle between shader_pipeline (master) and vector_processor (slave).
interface vector_processor_if #(
  parameter int DATA_WIDTH   = vp_pkg::VP_DW,
  parameter int VECTOR_WIDTH = vp_pkg::VP_VW
);

  logic                                 start;
  logic [3:0]                           operation;
  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   vec_a;
  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   vec_b;
  logic [DATA_WIDTH-1:0]                scalar;
  logic                                 busy;
  logic                                 done;
  logic [VECTOR_WIDTH*DATA_WIDTH-1:0]   result;
  logic                                 result_valid;

  modport master (
    output start, operation, vec_a, vec_b, scalar,
    input  busy, done, result, result_valid
  );

  modport slave (
    input  start, operation, vec_a, vec_b, scalar,
    output busy, done, result, result_valid
  );

endinterface

// File: rtl/vp_isqrt.sv
// Restoring integer square root: 34-bit radicand, 17-bit root, one root bit per cycle.
// The first bit is resolved on the load edge so the root is final SQRT_ITER-1 edges later.
module vp_isqrt
  import vp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic [33:0] i_radicand,
  output logic        o_busy,
  output logic        o_done,
  output logic [16:0] o_root
);

  logic [33:0] r_x;
  logic [17:0] r_rem;
  logic [16:0] r_root;
  logic [4:0]  r_cnt;
  logic        r_busy;
  logic        r_done;

  logic [1:0]  w_pair;
  logic [17:0] w_rem_in;
  logic [16:0] w_root_in;
  logic [19:0] w_rem_sh;
  logic [19:0] w_trial;
  logic [19:0] w_diff;
  logic        w_fits;
  logic [17:0] w_rem_next;
  logic [16:0] w_root_next;
  logic [33:0] w_x_next;
  logic        w_unused;

  // Remainder never exceeds 2*root, so 18 bits hold it and the partial root's MSB is still 0.
  always_comb begin
    w_pair      = i_load ? i_radicand[33:32] : r_x[33:32];
    w_rem_in    = i_load ? 18'd0 : r_rem;
    w_root_in   = i_load ? 17'd0 : r_root;
    w_rem_sh    = {w_rem_in, w_pair};
    w_trial     = {1'b0, w_root_in, 2'b01};
    w_diff      = w_rem_sh - w_trial;
    w_fits      = (w_rem_sh >= w_trial);
    w_rem_next  = w_fits ? w_diff[17:0] : w_rem_sh[17:0];
    w_root_next = {w_root_in[15:0], w_fits};
    w_x_next    = i_load ? {i_radicand[31:0], 2'b00} : {r_x[31:0], 2'b00};
  end

  assign w_unused = ^{w_diff[19:18], w_root_in[16]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x    <= '0;
      r_rem  <= '0;
      r_root <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_load) begin
        r_x    <= w_x_next;
        r_rem  <= w_rem_next;
        r_root <= w_root_next;
        r_cnt  <= 5'(SQRT_ITER - 1);
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_x    <= w_x_next;
        r_rem  <= w_rem_next;
        r_root <= w_root_next;
        r_cnt  <= r_cnt - 5'd1;
        if (r_cnt == 5'd1) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_root = r_root;

endmodule

// File: rtl/vector_processor.sv
// Shader vector responder: one lane per cycle through a shared 17x17 signed multiplier,
// with an iterative square root tail for LENGTH. All interface outputs are registered.
module vector_processor
  import vp_pkg::*;
#(
  parameter int DATA_WIDTH   = VP_DW,
  parameter int VECTOR_WIDTH = VP_VW
)
(
  input logic               clk,
  input logic               rst_n,
  vector_processor_if.slave bus
);

  localparam int VBITS  = VECTOR_WIDTH * DATA_WIDTH;
  localparam int LANE_W = (VECTOR_WIDTH > 1) ? $clog2(VECTOR_WIDTH) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(VECTOR_WIDTH - 1);

  vp_state_t r_state, w_state_next;

  logic [3:0]            r_op;
  logic [VBITS-1:0]      r_a, r_b, r_staging, r_result;
  logic [DATA_WIDTH-1:0] r_scalar;
  logic [LANE_W-1:0]     r_lane;
  logic signed [33:0]    r_acc;
  logic                  r_busy, r_done;

  logic [VBITS-1:0]      w_staging_next, w_final;
  logic [DATA_WIDTH-1:0] w_lane_a, w_lane_b, w_abs_a, w_lane_val;
  logic [DATA_WIDTH-1:0] w_mul_sat, w_dot_sat, w_len_sat;
  logic signed [16:0]    w_mul_x, w_mul_y;
  logic signed [33:0]    w_product, w_acc_next, w_dot_shift;
  logic                  w_capture, w_complete, w_sqrt_load, w_last_lane;
  logic                  w_sqrt_busy, w_sqrt_done, w_unused;
  logic [16:0]           w_root;

  assign w_lane_a    = lane_slice(r_a, int'(r_lane));
  assign w_lane_b    = lane_slice(r_b, int'(r_lane));
  assign w_abs_a     = w_lane_a[15] ? (~w_lane_a + 16'd1) : w_lane_a;
  assign w_last_lane = (r_lane == LAST_LANE);

  // Signed ops sign-extend into the 17-bit multiplier port; unsigned ops zero-extend.
  always_comb begin
    w_mul_x = '0;
    w_mul_y = '0;
    case (r_op)
      OP_DOT:    begin w_mul_x = {w_lane_a[15], w_lane_a}; w_mul_y = {w_lane_b[15], w_lane_b}; end
      OP_MUL:    begin w_mul_x = {1'b0, w_lane_a};         w_mul_y = {1'b0, w_lane_b};         end
      OP_SCALE:  begin w_mul_x = {1'b0, w_lane_a};         w_mul_y = {1'b0, r_scalar};         end
      OP_LENGTH: begin w_mul_x = {1'b0, w_abs_a};          w_mul_y = {1'b0, w_abs_a};          end
      default:   ;
    endcase
  end

  assign w_product  = 34'(w_mul_x) * 34'(w_mul_y);
  assign w_mul_sat  = (|w_product[31:24]) ? 16'hFFFF : w_product[23:8];
  assign w_acc_next = ((r_op == OP_DOT) || (r_op == OP_LENGTH)) ? (r_acc + w_product) : r_acc;

  always_comb begin
    w_lane_val = '0;
    case (r_op)
      OP_ADD:           w_lane_val = w_lane_a + w_lane_b;
      OP_SUB:           w_lane_val = w_lane_a - w_lane_b;
      OP_MUL, OP_SCALE: w_lane_val = w_mul_sat;
      default:          ;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < VECTOR_WIDTH; gi++) begin : g_lane
      assign w_staging_next[(VECTOR_WIDTH-gi)*DATA_WIDTH-1 -: DATA_WIDTH] =
        (r_lane == LANE_W'(gi)) ? w_lane_val
                                : r_staging[(VECTOR_WIDTH-gi)*DATA_WIDTH-1 -: DATA_WIDTH];
    end
  endgenerate

  assign w_dot_shift = w_acc_next >>> 8;

  always_comb begin
    if (w_dot_shift > 34'sd32767)       w_dot_sat = 16'h7FFF;
    else if (w_dot_shift < -34'sd32768) w_dot_sat = 16'h8000;
    else                                w_dot_sat = w_dot_shift[15:0];
  end

  assign w_len_sat = w_root[16] ? 16'hFFFF : w_root[15:0];

  always_comb begin
    w_final = w_staging_next;
    if (r_op == OP_DOT)         w_final = {w_dot_sat, {(VBITS-DATA_WIDTH){1'b0}}};
    else if (r_op == OP_LENGTH) w_final = {w_len_sat, {(VBITS-DATA_WIDTH){1'b0}}};
  end

  vp_isqrt u_isqrt (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_sqrt_load),
    .i_radicand ($unsigned(w_acc_next)),
    .o_busy     (w_sqrt_busy),
    .o_done     (w_sqrt_done),
    .o_root     (w_root)
  );

  assign w_unused = w_sqrt_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_complete   = 1'b0;
    w_sqrt_load  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_capture    = 1'b1;
          w_state_next = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (w_last_lane) begin
          if (r_op == OP_LENGTH) begin
            w_sqrt_load  = 1'b1;
            w_state_next = ST_SQRT;
          end else begin
            w_complete   = 1'b1;
            w_state_next = ST_IDLE;
          end
        end
      end
      ST_SQRT: begin
        if (w_sqrt_done) begin
          w_complete   = 1'b1;
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_scalar  <= '0;
      r_lane    <= '0;
      r_acc     <= '0;
      r_staging <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_complete;
      if (w_capture) begin
        r_op      <= bus.operation;
        r_a       <= bus.vec_a;
        r_b       <= bus.vec_b;
        r_scalar  <= bus.scalar;
        r_lane    <= '0;
        r_acc     <= '0;
        r_staging <= '0;
        r_busy    <= 1'b1;
      end
      if (r_state == ST_EXEC) begin
        r_lane    <= r_lane + LANE_W'(1);
        r_staging <= w_staging_next;
        r_acc     <= w_acc_next;
      end
      if (w_complete) begin
        r_busy   <= 1'b0;
        r_result <= w_final;
      end
    end
  end

  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.result_valid = r_done;
  assign bus.result       = r_result;

endmodule
